// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, coefficient type and parse FSM state encoding.
package kyber_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned KYBER_N = 256;

    typedef logic [11:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT2,
        DONE
    } parse_state_e;

endpackage

// File: rtl/parse_ctrl_if.sv
// parse_ctrl_if: XOF byte-stream valid/ready channel, three bytes per beat.
interface parse_ctrl_if;

    logic [23:0] xof_data;
    logic        xof_valid;
    logic        xof_ready;

    modport master (output xof_data, output xof_valid, input xof_ready);
    modport slave  (input xof_data, input xof_valid, output xof_ready);

endinterface

// File: rtl/parse_unpack.sv
// parse_unpack: splits one 3-byte group into two 12-bit candidates and flags
// those below Q. Purely combinational so any sampler can reuse it.
module parse_unpack
    import kyber_pkg::*;
(
    input  logic [23:0] grp,
    output coef_t       d1,
    output coef_t       d2,
    output logic        d1_ok,
    output logic        d2_ok
);

    // d1 = {b1[3:0], b0}, d2 = {b2, b1[7:4]}; plain 12-bit compare, no reduction
    always_comb begin
        d1    = {grp[11:8], grp[7:0]};
        d2    = {grp[23:16], grp[15:12]};
        d1_ok = (d1 < coef_t'(KYBER_Q));
        d2_ok = (d2 < coef_t'(KYBER_Q));
    end

endmodule

// File: rtl/parse_ctrl.sv
// parse_ctrl: rejection-sampling controller. Pulls 3-byte XOF groups, keeps
// candidates below Q and writes them one per cycle, ascending, into the
// polynomial RAM until 256 are stored or the group budget runs out.
module parse_ctrl
    import kyber_pkg::*;
#(
    parameter int unsigned MAX_GROUPS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    parse_ctrl_if.slave xof,
    output logic        coef_we,
    output logic [7:0]  coef_addr,
    output coef_t       coef_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [10:0] groups_used
);

    parse_state_e state;
    logic [8:0]   count;
    coef_t        d2_q;

    coef_t        d1, d2;
    logic         d1_ok, d2_ok;

    logic         xfer;
    logic         any_ok;
    logic [8:0]   count_inc;
    logic [10:0]  groups_inc;
    logic         count_full;
    logic         groups_out_now;
    logic         groups_out;

    parse_unpack u_unpack (
        .grp   (xof.xof_data),
        .d1    (d1),
        .d2    (d2),
        .d1_ok (d1_ok),
        .d2_ok (d2_ok)
    );

    // Handshake and look-ahead of the counters for this cycle's decision
    always_comb begin
        xfer           = xof.xof_ready & xof.xof_valid;
        any_ok         = d1_ok | d2_ok;
        count_inc      = count + 9'd1;
        groups_inc     = groups_used + 11'd1;
        count_full     = (count_inc == 9'(KYBER_N));
        groups_out_now = (groups_inc >= 11'(MAX_GROUPS));
        groups_out     = (groups_used >= 11'(MAX_GROUPS));
    end

    // Control FSM with registered handshake, RAM-write and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            d2_q          <= '0;
            xof.xof_ready <= 1'b0;
            coef_we       <= 1'b0;
            coef_addr     <= '0;
            coef_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            groups_used   <= '0;
        end else if (abort) begin
            state         <= IDLE;
            xof.xof_ready <= 1'b0;
            coef_we       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            coef_we <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= FETCH;
                        count         <= '0;
                        groups_used   <= '0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        xof.xof_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (xfer) begin
                        groups_used <= groups_inc;
                        if (any_ok) begin
                            coef_we   <= 1'b1;
                            coef_addr <= count[7:0];
                            coef_data <= d1_ok ? d1 : d2;
                            count     <= count_inc;
                        end
                        if (d1_ok && d2_ok && !count_full) begin
                            // d2 lands next cycle; the group limit is judged after it
                            d2_q          <= d2;
                            state         <= EMIT2;
                            xof.xof_ready <= 1'b0;
                        end else if (any_ok && count_full) begin
                            state         <= DONE;
                            xof.xof_ready <= 1'b0;
                        end else if (groups_out_now) begin
                            err           <= 1'b1;
                            state         <= DONE;
                            xof.xof_ready <= 1'b0;
                        end
                    end
                end
                EMIT2: begin
                    coef_we   <= 1'b1;
                    coef_addr <= count[7:0];
                    coef_data <= d2_q;
                    count     <= count_inc;
                    if (count_full) begin
                        state <= DONE;
                    end else if (groups_out) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state         <= FETCH;
                        xof.xof_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parse_ctrl.sv
// tb_parse_ctrl: directed self-checking bench for parse_ctrl (default budget)
// and a second instance with an 8-group budget for the exhaustion cases.
module tb_parse_ctrl;
    import kyber_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, start8, abort8;

    parse_ctrl_if xa ();
    parse_ctrl_if x8 ();

    logic        we, busy, done, err;
    logic [7:0]  addr;
    coef_t       cdata;
    logic [10:0] gu;

    logic        we8, busy8, done8, err8;
    logic [7:0]  addr8;
    coef_t       cdata8;
    logic [10:0] gu8;

    parse_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .xof(xa),
        .coef_we(we), .coef_addr(addr), .coef_data(cdata),
        .busy(busy), .done(done), .err(err), .groups_used(gu)
    );

    parse_ctrl #(.MAX_GROUPS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .xof(x8),
        .coef_we(we8), .coef_addr(addr8), .coef_data(cdata8),
        .busy(busy8), .done(done8), .err(err8), .groups_used(gu8)
    );

    int unsigned ntests = 0;
    int unsigned nfail  = 0;

    logic [7:0]  log_addr [0:2047];
    coef_t       log_data [0:2047];
    int unsigned nlog = 0, ndone = 0, nbusy = 0, nready = 0;
    logic [7:0]  log8_addr [0:15];
    coef_t       log8_data [0:15];
    int unsigned nlog8 = 0;

    // Record every RAM write and count status cycles, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            if (nlog < 2048) begin
                log_addr[nlog] <= addr;
                log_data[nlog] <= cdata;
            end
            nlog <= nlog + 1;
        end
        if (done) ndone <= ndone + 1;
        if (busy) nbusy <= nbusy + 1;
        if (xa.xof_ready) nready <= nready + 1;
        if (we8) begin
            if (nlog8 < 16) begin
                log8_addr[nlog8] <= addr8;
                log8_data[nlog8] <= cdata8;
            end
            nlog8 <= nlog8 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one group (valid with given duty %) until it transfers; ends on a negedge
    task automatic send(input logic [23:0] pat, input int unsigned duty);
        bit sent;
        int unsigned t;
        sent = 1'b0;
        t = 0;
        while (!sent && t < 200) begin
            xa.xof_data  = pat;
            xa.xof_valid = ($urandom_range(99) < duty);
            sent = xa.xof_valid && xa.xof_ready;
            @(negedge clk);
            t++;
        end
        chk("xfer_bound", 32'(sent), 32'd1);
    endtask

    task automatic send8(input logic [23:0] pat);
        bit sent;
        int unsigned t;
        sent = 1'b0;
        t = 0;
        while (!sent && t < 200) begin
            x8.xof_data  = pat;
            x8.xof_valid = 1'b1;
            sent = x8.xof_ready;
            @(negedge clk);
            t++;
        end
        chk("xfer8_bound", 32'(sent), 32'd1);
    endtask

    task automatic wait_done(input bit use8, input string tag);
        int unsigned t;
        t = 0;
        while (!(use8 ? done8 : done) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(use8 ? done8 : done), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Expected stream from 0x000001 groups: 1 at even addresses, 0 at odd
    task automatic check_alt(input int unsigned base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            chk("alt_write", 32'({log_addr[base+i], log_data[base+i]}),
                32'({8'(i), coef_t'((i % 2 == 0) ? 1 : 0)}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b_log, b_done, b_busy, b_ready, b8;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start8 = 1'b0; abort8 = 1'b0;
        xa.xof_valid = 1'b0; xa.xof_data = '0;
        x8.xof_valid = 1'b0; x8.xof_data = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_ctrl", 32'({we, busy, done, err, xa.xof_ready}), 32'd0);
        chk("rst_bus", 32'({addr, cdata}), 32'd0);
        chk("rst_groups", 32'(gu), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // start together with abort: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort", 32'({busy, xa.xof_ready}), 32'd0);

        // test 1: 128 groups of 0x000001, continuous valid
        b_log = nlog; b_done = ndone; b_busy = nbusy; b_ready = nready;
        pulse_start();
        for (int i = 0; i < 128; i++) send(24'h000001, 100);
        xa.xof_valid = 1'b0;
        wait_done(1'b0, "t1_done");
        chk("t1_end_state", 32'({busy, err, we}), 32'd0);
        chk("t1_groups", 32'(gu), 32'd128);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_nwrites", nlog - b_log, 32'd256);
        check_alt(b_log, 256);
        chk("t1_busy_cycles", nbusy - b_busy, 32'd257);
        chk("t1_ready_cycles", nready - b_ready, 32'd128);
        chk("t1_ndone", ndone - b_done, 32'd1);

        // test 2: Q boundary candidates
        b_log = nlog;
        pulse_start();
        send(24'h000D00, 100);
        send(24'h000D01, 100);
        send(24'hFFFFFF, 100);
        xa.xof_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_nwrites", nlog - b_log, 32'd3);
        chk("t2_w0", 32'({log_addr[b_log], log_data[b_log]}), 32'({8'd0, 12'd3328}));
        chk("t2_w1", 32'({log_addr[b_log+1], log_data[b_log+1]}), 32'({8'd1, 12'd0}));
        chk("t2_w2", 32'({log_addr[b_log+2], log_data[b_log+2]}), 32'({8'd2, 12'd0}));
        chk("t2_groups", 32'(gu), 32'd3);
        chk("t2_busy", 32'({busy, done}), 32'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t2_abort", 32'(busy), 32'd0);

        // test 3: last coefficient from a double-accept group drops d2
        b_log = nlog; b_done = ndone;
        pulse_start();
        for (int i = 0; i < 127; i++) send(24'h000001, 100);
        send(24'hFFF005, 100);
        send(24'h000001, 100);
        xa.xof_valid = 1'b0;
        wait_done(1'b0, "t3_done");
        chk("t3_err", 32'(err), 32'd0);
        chk("t3_groups", 32'(gu), 32'd129);
        repeat (4) @(negedge clk);
        chk("t3_nwrites", nlog - b_log, 32'd256);
        check_alt(b_log, 254);
        chk("t3_w254", 32'({log_addr[b_log+254], log_data[b_log+254]}), 32'({8'd254, 12'd5}));
        chk("t3_w255", 32'({log_addr[b_log+255], log_data[b_log+255]}), 32'({8'd255, 12'd1}));
        chk("t3_ndone", ndone - b_done, 32'd1);

        // test 4: 30% valid duty, same write sequence as test 1
        b_log = nlog;
        pulse_start();
        for (int i = 0; i < 128; i++) send(24'h000001, 30);
        xa.xof_valid = 1'b0;
        wait_done(1'b0, "t4_done");
        chk("t4_groups", 32'(gu), 32'd128);
        repeat (3) @(negedge clk);
        chk("t4_nwrites", nlog - b_log, 32'd256);
        check_alt(b_log, 256);

        // test 5: 8-group budget, all candidates rejected
        b8 = nlog8;
        x8.xof_data = 24'hFFFFFF; x8.xof_valid = 1'b1;
        pulse_start8();
        wait_done(1'b1, "t5_done");
        chk("t5_err", 32'(err8), 32'd1);
        chk("t5_groups", 32'(gu8), 32'd8);
        x8.xof_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_nwrites", nlog8 - b8, 32'd0);
        chk("t5_err_sticky", 32'(err8), 32'd1);
        pulse_start8();
        chk("t5_restart_clears_err", 32'({err8, busy8}), 32'b01);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        chk("t5_abort_keeps_err", 32'({err8, busy8}), 32'd0);

        // test 5b: budget runs out on a group that leaves d2 pending
        b8 = nlog8;
        pulse_start8();
        for (int i = 0; i < 7; i++) send8(24'hFFFFFF);
        send8(24'h000001);
        x8.xof_valid = 1'b0;
        wait_done(1'b1, "t5b_done");
        chk("t5b_err", 32'(err8), 32'd1);
        chk("t5b_groups", 32'(gu8), 32'd8);
        repeat (3) @(negedge clk);
        chk("t5b_nwrites", nlog8 - b8, 32'd2);
        chk("t5b_w0", 32'({log8_addr[b8], log8_data[b8]}), 32'({8'd0, 12'd1}));
        chk("t5b_w1", 32'({log8_addr[b8+1], log8_data[b8+1]}), 32'({8'd1, 12'd0}));

        // test 6: abort at count 100, restart, then async reset mid-EMIT2
        b_log = nlog; b_done = ndone;
        pulse_start();
        for (int i = 0; i < 50; i++) send(24'h000001, 100);
        xa.xof_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort_outs", 32'({we, busy, done, xa.xof_ready}), 32'd0);
        repeat (5) @(negedge clk);
        chk("t6_nwrites", nlog - b_log, 32'd100);
        chk("t6_no_done", ndone - b_done, 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        pulse_start();
        send(24'h000D00, 100);
        chk("t6_restart_w0", 32'({we, addr, cdata}), 32'({1'b1, 8'd0, 12'd3328}));
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'({we, busy, done, err, xa.xof_ready}), 32'd0);
        chk("t6_rst_bus", 32'({addr, cdata}), 32'd0);
        chk("t6_rst_groups", 32'(gu), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_idle_after_rst", 32'({we, busy, done, xa.xof_ready}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/parse_ctrl.md
Name: parse_ctrl

Overview:
Sequential rejection-sampling controller for matrix A generation (Kyber-768-90s).
- Consumes the XOF byte stream three bytes per beat over a valid/ready handshake.
- Extracts two 12-bit candidates per beat and keeps those below Q.
- Writes accepted coefficients one per cycle into the polynomial RAM until 256 are stored.
- Sits between the AES-CTR XOF wrapper and the NTT-domain polynomial memory, started by the matrix-generation scheduler.

Parameters:
Q, 3329, modulus; candidate accepted iff value < Q
N, 256, coefficients per polynomial
MAX_GROUPS, 1024, 3-byte groups consumed before aborting with error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a polynomial when idle
abort  in  1  synchronous clear to IDLE
xof_data  in  24  bytes b0=[7:0], b1=[15:8], b2=[23:16]
xof_valid  in  1  xof_data valid
xof_ready  out  1  controller accepts group this cycle
coef_we  out  1  RAM write enable
coef_addr  out  8  coefficient index
coef_data  out  12  coefficient value
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at completion (success or error)
err  out  1  sticky until next start; MAX_GROUPS exhausted
groups_used  out  11  groups consumed in current/last run

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0; internal count=0, pending register cleared.
- Candidates:
  - d1 = {b1[3:0], b0}; d2 = {b2, b1[7:4]}; both 12-bit unsigned.
  - Compare against Q in 12 bits; no modular reduction.
- FSM states: IDLE, FETCH, EMIT2, DONE.
- IDLE:
  - xof_ready=0.
  - start -> FETCH; clears count, groups_used and err.
  - start ignored in every other state.
- FETCH:
  - xof_ready=1; a group transfers when xof_valid & xof_ready. groups_used increments on each transfer.
  - d1 ok, d2 ok, count<=N-2: write d1 at count, latch d2, go to EMIT2.
  - d1 ok, d2 ok, count==N-1: write d1 only; d2 dropped; go to DONE.
  - Exactly one candidate ok: write it at count; stay in FETCH (or DONE if count reaches N).
  - Neither ok: no write.
  - count increments per write. Reaching N -> DONE.
  - No transfer (xof_valid=0): no write, state held.
- EMIT2:
  - xof_ready=0; write latched d2 at count; count++.
  - count==N -> DONE, else FETCH.
- MAX_GROUPS exhaustion:
  - If groups_used reaches MAX_GROUPS in FETCH and count<N after the transfer's write: err=1 -> DONE.
  - Exhaustion on a transfer that leaves d2 pending: EMIT2 completes first, then err is evaluated.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle; coef_we=0 -> IDLE.
- Outputs:
  - coef_we, coef_addr and coef_data are registered: they present the write in the cycle after the acceptance decision.
  - Write order is strictly ascending addresses 0..255, no gaps, no duplicates.
- abort:
  - Overrides all states -> IDLE next cycle; coef_we=0, xof_ready=0.
  - No done pulse; err unchanged.
- Async reset mid-operation: immediate IDLE; in-flight group discarded.
- Concurrent start and abort: abort wins.
- Throughput: one group per cycle when ≤1 candidate accepted; two cycles when both accepted.

Decomposition:
- Package kyber_pkg:
  - KYBER_Q=3329, KYBER_N=256.
  - coef_t (logic [11:0]).
  - parse_state_e enum.
- Sub-module parse_unpack (combinational):
  - Inputs: 24-bit group.
  - Outputs: d1, d2, d1_ok, d2_ok.
  - Shared with any future sampler.

Test Plan:
1. start; stream 128 groups 0x000001 (d1=1, d2=0, both ok) -> 256 writes alternating 1,0 at addr 0..255; xof_ready low every second cycle; done after 128 groups; groups_used=128.
2. Boundary: group 0x000D00 (d1=3328, d2=0) accepted both; group 0x000D01 (d1=3329 rejected, d2=0 accepted) -> only d2 written, same-cycle decision; 0xFFFFFF -> no write.
3. Last coefficient: run to count=255, then send 0x000001 -> d1=1 written at addr 255, d2 dropped, done pulse, err=0, no write at addr 256.
4. Backpressure: xof_valid random 30% duty with test-1 data -> identical write sequence to test 1; no group lost or repeated.
5. MAX_GROUPS=8 override; send 0xFFFFFF continuously -> zero writes, after 8th group done=1, err=1, groups_used=8; next start clears err.
6. abort at count=100 -> IDLE next cycle, no done; new start restarts writes at addr 0. Assert rst_n mid-EMIT2 -> outputs 0 immediately.
